// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified memory port arbiter: state encoding and default bus widths.
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] IF_BUSY = 2'd1;
   localparam logic [1:0] D_BUSY  = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data accesses,
// holding each request through the memory handshake and returning completion pulses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifReq,
   input  logic [ADDR_W-1:0] ifAddr,
   input  logic              flush,
   output logic [DATA_W-1:0] ifData,
   output logic              ifValid,
   input  logic              dReq,
   input  logic              dWe,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] dWData,
   output logic [DATA_W-1:0] dRData,
   output logic              dValid,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic [DATA_W-1:0] memRData,
   input  logic              memAck,
   output logic              stallIF,
   output logic              stallMem
);

   logic [1:0] state;
   logic [1:0] stateNext;
   logic       ifEligible;
   logic       dEligible;
   logic       grantIf;
   logic       grantD;
   logic       ifAck;
   logic       dAck;
   logic       killed;

   // A requester is masked in its own completion cycle so it is never served twice.
   assign ifEligible = ifReq & ~flush & ~ifValid;
   assign dEligible  = dReq & ~dValid;
   assign ifAck      = (state == IF_BUSY) & memAck;
   assign dAck       = (state == D_BUSY) & memAck;

   assign stallIF  = ifReq & ~ifValid;
   assign stallMem = dReq & ~dValid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Data outranks fetch in IDLE; on an ack the other requester is served back-to-back.
   always_comb begin
      stateNext = state;
      grantIf   = 1'b0;
      grantD    = 1'b0;
      case (state)
         IDLE: begin
            if (dEligible) begin
               grantD    = 1'b1;
               stateNext = D_BUSY;
            end else if (ifEligible) begin
               grantIf   = 1'b1;
               stateNext = IF_BUSY;
            end
         end
         IF_BUSY: begin
            if (memAck) begin
               if (dEligible) begin
                  grantD    = 1'b1;
                  stateNext = D_BUSY;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         D_BUSY: begin
            if (memAck) begin
               if (ifEligible) begin
                  grantIf   = 1'b1;
                  stateNext = IF_BUSY;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Memory-side request register, result registers and fetch-kill flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         memReq   <= 1'b0;
         memWe    <= 1'b0;
         memAddr  <= '0;
         memWData <= '0;
         ifValid  <= 1'b0;
         dValid   <= 1'b0;
         ifData   <= '0;
         dRData   <= '0;
         killed   <= 1'b0;
      end else begin
         ifValid <= ifAck & ~killed & ~flush;
         dValid  <= dAck;

         if (ifAck) begin
            ifData <= memRData;
         end
         if (dAck) begin
            dRData <= memRData;
         end

         // A flushed fetch still finishes on the bus; only its result is dropped.
         if (ifAck) begin
            killed <= 1'b0;
         end else if ((state == IF_BUSY) && flush) begin
            killed <= 1'b1;
         end

         if (grantD) begin
            memReq   <= 1'b1;
            memWe    <= dWe;
            memAddr  <= dAddr;
            memWData <= dWData;
         end else if (grantIf) begin
            memReq   <= 1'b1;
            memWe    <= 1'b0;
            memAddr  <= ifAddr;
            memWData <= '0;
         end else if (ifAck || dAck) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by randomized
// fetch/data traffic against a simple memory device and a reference data-memory model.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst;
   logic          ifReq;
   logic [AW-1:0] ifAddr;
   logic          flush;
   logic [DW-1:0] ifData;
   logic          ifValid;
   logic          dReq;
   logic          dWe;
   logic [AW-1:0] dAddr;
   logic [DW-1:0] dWData;
   logic [DW-1:0] dRData;
   logic          dValid;
   logic          memReq;
   logic          memWe;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWData;
   logic [DW-1:0] memRData;
   logic          memAck;
   logic          stallIF;
   logic          stallMem;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] ifExpQ[$];
   logic [32:0] dExpQ[$];           // bit 32 set = store (no data check)
   logic [31:0] devMem [logic [31:0]];
   logic [31:0] refMem [logic [31:0]];

   int memLat   = 0;                // <0 selects a random latency per transaction
   bit strayAck = 0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .ifReq(ifReq), .ifAddr(ifAddr), .flush(flush), .ifData(ifData), .ifValid(ifValid),
      .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData), .dRData(dRData), .dValid(dValid),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
      .memRData(memRData), .memAck(memAck),
      .stallIF(stallIF), .stallMem(stallMem)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] refRead(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : hash(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic failNote(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: event not expected / not seen at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitFor(input bit isIf, input string name);
      for (int i = 0; i < 40; i++) begin
         if (isIf ? ifValid : dValid) return;
         tick();
      end
      failNote(name);
   endtask

   // Memory device: latches each transaction, checks it is held stable, acks after memLat cycles.
   logic [31:0] tA, tWD;
   logic        tWe;
   bit          inTxn = 0;
   int          lat = 0;
   int          cnt = 0;
   initial begin
      memAck   = 1'b0;
      memRData = '0;
      devMem[32'h40] = 32'h2002_0005;
      forever begin
         @(posedge clk);
         #2;
         memAck = 1'b0;
         if (rst) begin
            inTxn = 0;
         end else begin
            if (!inTxn && memReq) begin
               inTxn = 1;
               tA    = memAddr;
               tWe   = memWe;
               tWD   = memWData;
               cnt   = 0;
               lat   = (memLat < 0) ? int'($urandom_range(0, 3)) : memLat;
            end
            if (inTxn) begin
               if (cnt > 0) begin
                  chk("memReq held", 32'(memReq), 32'd1);
                  chk("memAddr stable", memAddr, tA);
                  chk("memWe stable", 32'(memWe), 32'(tWe));
                  chk("memWData stable", memWData, tWD);
               end
               if (cnt == lat) begin
                  memAck = 1'b1;
                  inTxn  = 0;
                  if (tWe) devMem[tA] = tWD;
                  else     memRData = devMem.exists(tA) ? devMem[tA] : hash(tA);
               end else begin
                  cnt++;
               end
            end else if (strayAck) begin
               memAck   = 1'b1;
               memRData = 32'hBAD0_BAD0;
               strayAck = 0;
            end
         end
      end
   end

   // Monitor: pops expected results whenever a completion pulse is presented.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (!ifReq) chk("stallIF idle", 32'(stallIF), 32'd0);
            else        chk("stallIF", 32'(stallIF), 32'(!ifValid));
            if (!dReq)  chk("stallMem idle", 32'(stallMem), 32'd0);
            else        chk("stallMem", 32'(stallMem), 32'(!dValid));
            if (ifValid) begin
               if (ifExpQ.size() == 0) failNote("ifValid unexpected");
               else chk("ifData", ifData, ifExpQ.pop_front());
            end
            if (dValid) begin
               if (dExpQ.size() == 0) failNote("dValid unexpected");
               else begin
                  e = dExpQ.pop_front();
                  if (!e[32]) chk("dRData", dRData, e[31:0]);
               end
            end
         end
      end
   end

   task automatic checkAllZero(input string tag);
      chk({tag, " memReq"}, 32'(memReq), 32'd0);
      chk({tag, " memWe"}, 32'(memWe), 32'd0);
      chk({tag, " memAddr"}, memAddr, 32'd0);
      chk({tag, " memWData"}, memWData, 32'd0);
      chk({tag, " ifValid"}, 32'(ifValid), 32'd0);
      chk({tag, " dValid"}, 32'(dValid), 32'd0);
      chk({tag, " ifData"}, ifData, 32'd0);
      chk({tag, " dRData"}, dRData, 32'd0);
   endtask

   initial begin
      bit ifHold, dHold, stopGen;
      int ifWait, dWait;
      logic [31:0] a, w;
      rst = 1'b1; ifReq = 1'b0; ifAddr = '0; flush = 1'b0;
      dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWData = '0;
      tick(); tick();
      rst = 1'b0;
      checkAllZero("reset");

      // Fetch only, ack in the first memReq cycle.
      memLat = 0;
      ifReq = 1'b1; ifAddr = 32'h40; ifExpQ.push_back(32'h2002_0005);
      tick();
      chk("fetch memReq", 32'(memReq), 32'd1);
      chk("fetch memAddr", memAddr, 32'h40);
      chk("fetch memWe", 32'(memWe), 32'd0);
      tick();
      chk("fetch ifValid t+2", 32'(ifValid), 32'd1);
      tick();
      chk("fetch no regrant", 32'(memReq), 32'd0);
      chk("fetch pulse width", 32'(ifValid), 32'd0);
      ifReq = 1'b0;
      tick();

      // Collision: data first, fetch back-to-back.
      memLat = 1;
      ifReq = 1'b1; ifAddr = 32'h44; ifExpQ.push_back(hash(32'h44));
      dReq = 1'b1; dWe = 1'b0; dAddr = 32'h100; dExpQ.push_back({1'b0, refRead(32'h100)});
      tick();
      chk("collision data first", memAddr, 32'h100);
      tick(); tick();
      chk("collision dValid", 32'(dValid), 32'd1);
      chk("collision b2b memReq", 32'(memReq), 32'd1);
      chk("collision b2b memAddr", memAddr, 32'h44);
      chk("collision stallIF", 32'(stallIF), 32'd1);
      tick();
      dReq = 1'b0;
      waitFor(1, "collision ifValid timeout");
      tick();
      ifReq = 1'b0;
      tick();

      // Store with 3-cycle ack latency, then read it back.
      memLat = 2;
      dReq = 1'b1; dWe = 1'b1; dAddr = 32'h200; dWData = 32'hDEAD_BEEF;
      refMem[32'h200] = 32'hDEAD_BEEF; dExpQ.push_back({1'b1, 32'h0});
      tick();
      chk("store memWe", 32'(memWe), 32'd1);
      chk("store memAddr", memAddr, 32'h200);
      chk("store memWData", memWData, 32'hDEAD_BEEF);
      waitFor(0, "store dValid timeout");
      tick();
      dWe = 1'b0;
      dExpQ.push_back({1'b0, refRead(32'h200)});
      waitFor(0, "load-back dValid timeout");
      tick();
      dReq = 1'b0;
      tick();

      // Flush one cycle into a 4-cycle fetch, then redirect to 0x80.
      memLat = 3;
      ifReq = 1'b1; ifAddr = 32'h60; ifExpQ.push_back(hash(32'h60));
      tick(); tick();
      flush = 1'b1; void'(ifExpQ.pop_back());
      tick();
      flush = 1'b0; ifAddr = 32'h80; ifExpQ.push_back(hash(32'h80));
      waitFor(1, "post-flush ifValid timeout");
      tick();
      ifReq = 1'b0;
      tick();

      // Reset in the middle of a data transaction, then a stray ack.
      memLat = 6;
      dReq = 1'b1; dWe = 1'b0; dAddr = 32'h104;
      tick(); tick();
      rst = 1'b1; dReq = 1'b0;
      tick();
      rst = 1'b0;
      checkAllZero("mid-reset");
      strayAck = 1;
      tick();
      chk("stray ack dValid", 32'(dValid), 32'd0);
      chk("stray ack ifValid", 32'(ifValid), 32'd0);
      tick();
      chk("stray ack memReq", 32'(memReq), 32'd0);

      // Randomized traffic.
      memLat = -1;
      ifHold = 0; dHold = 0; ifWait = 0; dWait = 0;
      for (int cyc = 0; cyc < 3300; cyc++) begin
         stopGen = (cyc >= 3000);
         flush = 1'b0;
         if (ifHold) begin
            ifHold = 0; ifReq = 1'b0;
         end else if (ifReq && ifValid) begin
            ifWait = 0;
            if ($urandom_range(0, 1) == 1) ifReq = 1'b0;
            else                           ifHold = 1;
         end else if (ifReq) begin
            ifWait++;
            if (ifWait > 60) begin
               failNote("fetch timeout");
               ifReq = 1'b0; ifExpQ.delete(); ifWait = 0;
            end else if ($urandom_range(0, 9) == 0) begin
               flush = 1'b1;
               void'(ifExpQ.pop_back());
               ifAddr = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
               ifExpQ.push_back(hash(ifAddr));
            end
         end else if (!stopGen && $urandom_range(0, 2) == 0) begin
            ifReq = 1'b1; ifWait = 0;
            ifAddr = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
            ifExpQ.push_back(hash(ifAddr));
         end

         if (dHold) begin
            dHold = 0; dReq = 1'b0;
         end else if (dReq && dValid) begin
            dWait = 0;
            if ($urandom_range(0, 1) == 1) dReq = 1'b0;
            else                           dHold = 1;
         end else if (dReq) begin
            dWait++;
            if (dWait > 60) begin
               failNote("data timeout");
               dReq = 1'b0; dExpQ.delete(); dWait = 0;
            end
         end else if (!stopGen && $urandom_range(0, 2) == 0) begin
            a = 32'h200 + 32'($urandom_range(0, 7)) * 4;
            w = $urandom;
            dReq = 1'b1; dAddr = a; dWait = 0;
            dWe = ($urandom_range(0, 1) == 1);
            dWData = w;
            if (dWe) begin
               refMem[a] = w;
               dExpQ.push_back({1'b1, 32'h0});
            end else begin
               dExpQ.push_back({1'b0, refRead(a)});
            end
         end
         tick();
      end

      chk("fetch queue drained", 32'(ifExpQ.size()), 32'd0);
      chk("data queue drained", 32'(dExpQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
